// File: rtl/cmlk_system_ctrl_regbank.sv
`default_nettype none
// =============================================================================
// Module   : cmlk_system_ctrl_regbank
// Brief    : AXI4-Lite register bank: RW control, RO status, W1C irq block.
//            Optional watchdog register enabled by macro CMLK_SYSCTRL_WDOG_EN.
// Revision : 1.0
// =============================================================================
module cmlk_system_ctrl_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CTRL           = 4,
  parameter int NUM_STAT           = 4,
  parameter int IRQ_WIDTH          = 8
) (
  input  logic                                             s00_axi_aclk,
  input  logic                                             s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                    s00_axi_awaddr,
  input  logic [2:0]                                       s00_axi_awprot,
  input  logic                                             s00_axi_awvalid,
  output logic                                             s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                    s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                  s00_axi_wstrb,
  input  logic                                             s00_axi_wvalid,
  output logic                                             s00_axi_wready,
  output logic [1:0]                                       s00_axi_bresp,
  output logic                                             s00_axi_bvalid,
  input  logic                                             s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                    s00_axi_araddr,
  input  logic [2:0]                                       s00_axi_arprot,
  input  logic                                             s00_axi_arvalid,
  output logic                                             s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                    s00_axi_rdata,
  output logic [1:0]                                       s00_axi_rresp,
  output logic                                             s00_axi_rvalid,
  input  logic                                             s00_axi_rready,
  output logic [NUM_CTRL*C_S_AXI_DATA_WIDTH-1:0]           ctrl_out,
  input  logic [(NUM_STAT>0?NUM_STAT:1)*C_S_AXI_DATA_WIDTH-1:0] stat_in,
  input  logic [IRQ_WIDTH-1:0]                             irq_src,
`ifdef CMLK_SYSCTRL_WDOG_EN
  output logic                                             wdog_expire,
`endif
  output logic                                             irq
);

  localparam int DW        = C_S_AXI_DATA_WIDTH;
  localparam int SW        = DW / 8;
  localparam int ADDR_LSB  = $clog2(SW);
  localparam int IDX_W     = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int ISTAT_IDX = NUM_CTRL + NUM_STAT;
  localparam int IEN_IDX   = ISTAT_IDX + 1;
`ifdef CMLK_SYSCTRL_WDOG_EN
  localparam int WDOG_IDX  = ISTAT_IDX + 2;
`endif

  typedef enum logic [2:0] {D_CTRL, D_STAT, D_ISTAT, D_IEN, D_WDOG, D_ERR} dec_e;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic dec_e decode(input logic [IDX_W-1:0] idx);
    int i;
    i = int'(idx);
    if (i < NUM_CTRL)        return D_CTRL;
    else if (i < ISTAT_IDX)  return D_STAT;
    else if (i == ISTAT_IDX) return D_ISTAT;
    else if (i == IEN_IDX)   return D_IEN;
`ifdef CMLK_SYSCTRL_WDOG_EN
    else if (i == WDOG_IDX)  return D_WDOG;
`endif
    return D_ERR;
  endfunction

  w_state_e                w_state_q;
  r_state_e                r_state_q;
  logic                    awready_q, wready_q, aw_held_q, w_held_q, bvalid_q;
  logic [1:0]              bresp_q;
  logic [IDX_W-1:0]        w_idx_q;
  logic [DW-1:0]           wdata_q;
  logic [SW-1:0]           wstrb_q;
  logic                    arready_q, rvalid_q;
  logic [1:0]              rresp_q;
  logic [DW-1:0]           rdata_q;
  logic [NUM_CTRL*DW-1:0]  ctrl_q, ctrl_d;
  logic [IRQ_WIDTH-1:0]    istat_q, istat_d, ien_q, ien_d, irq_src_q, wdog_set;
  logic                    irq_q;
  logic [DW-1:0]           w_mask, r_val;
  logic [IRQ_WIDTH-1:0]    w_clr;
  logic                    w_do_write;
  dec_e                    w_dec, r_dec;
  logic [IDX_W-1:0]        r_idx;
  logic                    unused_ok;

  assign unused_ok  = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};
  assign w_do_write = (w_state_q == W_IDLE) && aw_held_q && w_held_q;
  assign w_dec      = decode(w_idx_q);
  assign r_idx      = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign r_dec      = decode(r_idx);

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < DW; b++) w_mask[b] = wstrb_q[b/8];
  end

`ifdef CMLK_SYSCTRL_WDOG_EN
  logic [DW-1:0] wdog_cnt_q;
  logic          wdog_expire_q;
  logic          w_wdog_load;

  assign w_wdog_load = w_do_write && (w_dec == D_WDOG);
  assign wdog_expire = wdog_expire_q;

  always_comb begin
    wdog_set = '0;
    wdog_set[IRQ_WIDTH-1] = !w_wdog_load && (wdog_cnt_q == DW'(1));
  end

  // A load of zero leaves the counter idle; expiry fires only on the 1->0 step.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wdog_cnt_q    <= '0;
      wdog_expire_q <= 1'b0;
    end else if (w_wdog_load) begin
      wdog_cnt_q    <= (wdog_cnt_q & ~w_mask) | (wdata_q & w_mask);
      wdog_expire_q <= 1'b0;
    end else if (wdog_cnt_q != '0) begin
      wdog_cnt_q <= wdog_cnt_q - DW'(1);
      if (wdog_cnt_q == DW'(1)) wdog_expire_q <= 1'b1;
    end
  end
`else
  assign wdog_set = '0;
`endif

  // Edge set is ORed after the W1C clear so a coincident edge wins.
  always_comb begin
    ctrl_d  = ctrl_q;
    ien_d   = ien_q;
    w_clr   = '0;
    if (w_do_write && w_dec == D_CTRL) begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (int'(w_idx_q) == k)
          ctrl_d[k*DW +: DW] = (ctrl_q[k*DW +: DW] & ~w_mask) | (wdata_q & w_mask);
      end
    end
    if (w_do_write && w_dec == D_IEN)
      ien_d = (ien_q & ~w_mask[IRQ_WIDTH-1:0]) | (wdata_q[IRQ_WIDTH-1:0] & w_mask[IRQ_WIDTH-1:0]);
    if (w_do_write && w_dec == D_ISTAT)
      w_clr = wdata_q[IRQ_WIDTH-1:0] & w_mask[IRQ_WIDTH-1:0];
    istat_d = (istat_q & ~w_clr) | (irq_src & ~irq_src_q) | wdog_set;
  end

  always_comb begin
    r_val = '0;
    case (r_dec)
      D_CTRL: begin
        for (int k = 0; k < NUM_CTRL; k++)
          if (int'(r_idx) == k) r_val = ctrl_q[k*DW +: DW];
      end
      D_STAT: begin
        for (int j = 0; j < NUM_STAT; j++)
          if (int'(r_idx) == NUM_CTRL + j) r_val = stat_in[j*DW +: DW];
      end
      D_ISTAT: r_val = DW'(istat_q);
      D_IEN:   r_val = DW'(ien_q);
`ifdef CMLK_SYSCTRL_WDOG_EN
      D_WDOG:  r_val = wdog_cnt_q;
`endif
      default: r_val = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      w_idx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      istat_q   <= '0;
      ien_q     <= '0;
      irq_src_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      ien_q     <= ien_d;
      istat_q   <= istat_d;
      irq_src_q <= irq_src;
      irq_q     <= |(istat_q & ien_q);

      case (w_state_q)
        W_IDLE: begin
          if (w_do_write) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= (w_dec == D_ERR) ? 2'b10 : 2'b00;
            w_state_q <= W_RESP;
          end else begin
            if (!aw_held_q) begin
              if (awready_q && s00_axi_awvalid) begin
                aw_held_q <= 1'b1;
                awready_q <= 1'b0;
                w_idx_q   <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
              end else begin
                awready_q <= 1'b1;
              end
            end
            if (!w_held_q) begin
              if (wready_q && s00_axi_wvalid) begin
                w_held_q <= 1'b1;
                wready_q <= 1'b0;
                wdata_q  <= s00_axi_wdata;
                wstrb_q  <= s00_axi_wstrb;
              end else begin
                wready_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          if (s00_axi_bready) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
      endcase

      case (r_state_q)
        R_IDLE: begin
          if (arready_q && s00_axi_arvalid) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= r_val;
            rresp_q   <= (r_dec == D_ERR) ? 2'b10 : 2'b00;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        default: begin
          if (s00_axi_rready) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign ctrl_out        = ctrl_q;
  assign irq             = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_cmlk_system_ctrl_regbank.sv
`default_nettype none
// =============================================================================
// Module   : tb_cmlk_system_ctrl_regbank
// Brief    : Self-checking bench for the AXI4-Lite system-control register bank.
// Revision : 1.0
// =============================================================================
module tb_cmlk_system_ctrl_regbank;
  localparam int TMO = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] ctrl_out, stat_in;
  logic [7:0]   irq_src;
  logic         irq;
`ifdef CMLK_SYSCTRL_WDOG_EN
  logic         wdog_expire;
`endif

  always #5 clk = ~clk;

  cmlk_system_ctrl_regbank dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .ctrl_out(ctrl_out), .stat_in(stat_in), .irq_src(irq_src),
`ifdef CMLK_SYSCTRL_WDOG_EN
    .wdog_expire(wdog_expire),
`endif
    .irq(irq)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int b_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    string       nm;
  } exp_t;

  exp_t rq[$];
  exp_t bq[$];

  typedef struct {
    bit          wr;
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] ed;
    logic [1:0]  er;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input logic [1:0] er,
                           input int bhold, input bit pulse, input string nm);
    exp_t e;
    int   tb;
    bq.push_back('{32'h0, er, nm});
    @(negedge clk);
    fork
      begin
        int ta;
        repeat (awd) @(negedge clk);
        awaddr = a; awvalid = 1'b1; ta = 0;
        while (!awready && ta < TMO) begin @(negedge clk); ta++; end
        check({nm, " aw_handshake"}, ta < TMO, 1'b1);
        @(posedge clk); #1 awvalid = 1'b0;
      end
      begin
        int tw;
        repeat (wd) @(negedge clk);
        wdata = d; wstrb = s; wvalid = 1'b1; tw = 0;
        while (!wready && tw < TMO) begin @(negedge clk); tw++; end
        check({nm, " w_handshake"}, tw < TMO, 1'b1);
        @(posedge clk); #1 wvalid = 1'b0;
      end
    join
    if (pulse) irq_src[0] = 1'b1;
    @(negedge clk);
    check({nm, " bvalid_early"}, bvalid, 1'b0);
    tb = 0;
    while (!bvalid && tb < TMO) begin @(negedge clk); tb++; end
    check({nm, " bvalid_timeout"}, tb < TMO, 1'b1);
    b_cyc = cyc;
    e = bq.pop_front();
    check({e.nm, " bresp"}, bresp, e.resp);
    repeat (bhold) begin
      @(negedge clk);
      check({nm, " bvalid_hold"}, bvalid, 1'b1);
    end
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input string nm);
    exp_t e;
    int   t;
    rq.push_back('{ed, er, nm});
    @(negedge clk);
    araddr = a; arvalid = 1'b1; t = 0;
    while (!arready && t < TMO) begin @(negedge clk); t++; end
    check({nm, " ar_handshake"}, t < TMO, 1'b1);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    check({nm, " rvalid_latency"}, rvalid, 1'b1);
    t = 0;
    while (!rvalid && t < TMO) begin @(negedge clk); t++; end
    e = rq.pop_front();
    check({e.nm, " rdata"}, rdata, e.data);
    check({e.nm, " rresp"}, rresp, e.resp);
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0; irq_src = '0;
    stat_in = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'hDEAD_BEEF};

    vecs[0]  = '{1'b1, 6'h00, 32'h0000_0001, 4'hF, 32'h0,          2'b00};
    vecs[1]  = '{1'b1, 6'h04, 32'h0000_0002, 4'hF, 32'h0,          2'b00};
    vecs[2]  = '{1'b1, 6'h08, 32'h0000_0003, 4'hF, 32'h0,          2'b00};
    vecs[3]  = '{1'b1, 6'h0C, 32'h0000_0004, 4'hF, 32'h0,          2'b00};
    vecs[4]  = '{1'b0, 6'h00, 32'h0,         4'h0, 32'h0000_0001,  2'b00};
    vecs[5]  = '{1'b0, 6'h04, 32'h0,         4'h0, 32'h0000_0002,  2'b00};
    vecs[6]  = '{1'b0, 6'h08, 32'h0,         4'h0, 32'h0000_0003,  2'b00};
    vecs[7]  = '{1'b0, 6'h0F, 32'h0,         4'h0, 32'h0000_0004,  2'b00};
    vecs[8]  = '{1'b1, 6'h10, 32'h1234_5678, 4'hF, 32'h0,          2'b00};
    vecs[9]  = '{1'b0, 6'h10, 32'h0,         4'h0, 32'hDEAD_BEEF,  2'b00};
    vecs[10] = '{1'b1, 6'h3C, 32'hFFFF_FFFF, 4'hF, 32'h0,          2'b10};
    vecs[11] = '{1'b0, 6'h3C, 32'h0,         4'h0, 32'h0,          2'b10};
    vecs[12] = '{1'b1, 6'h2C, 32'h0,         4'hF, 32'h0,          2'b10};
    vecs[13] = '{1'b1, 6'h24, 32'hFFFF_FF03, 4'h1, 32'h0,          2'b00};
    vecs[14] = '{1'b0, 6'h24, 32'h0,         4'h0, 32'h0000_0003,  2'b00};
    vecs[15] = '{1'b0, 6'h20, 32'h0,         4'h0, 32'h0,          2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst awready", awready, 1'b0);
    check("rst arready", arready, 1'b0);
    check("rst bvalid", bvalid, 1'b0);
    check("rst rvalid", rvalid, 1'b0);
    check("rst ctrl_out", ctrl_out, 128'h0);
    check("rst irq", irq, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr)
        axi_write(vecs[i].a, vecs[i].d, vecs[i].s, 0, 0, vecs[i].er, 0, 1'b0, $sformatf("vec%0d", i));
      else
        axi_read(vecs[i].a, vecs[i].ed, vecs[i].er, $sformatf("vec%0d", i));
    end
    check("ctrl_out after table", ctrl_out, {32'h4, 32'h3, 32'h2, 32'h1});

    // Independent AW/W ordering, byte strobes, bready back-pressure
    axi_write(6'h04, 32'hAABB_CCDD, 4'b0010, 0, 3, 2'b00, 0, 1'b0, "aw_first");
    axi_write(6'h08, 32'h1122_3344, 4'b1100, 3, 0, 2'b00, 5, 1'b0, "w_first");
    axi_read(6'h04, 32'h0000_CC02, 2'b00, "rd_aw_first");
    axi_read(6'h08, 32'h1122_0003, 2'b00, "rd_w_first");

    // Interrupt edge capture, enable, W1C priority and strobes
    axi_write(6'h24, 32'h0000_0001, 4'hF, 0, 0, 2'b00, 0, 1'b0, "ien_set");
    @(negedge clk); irq_src = 8'h01;
    @(negedge clk); irq_src = 8'h00;
    check("irq one cycle behind status", irq, 1'b0);
    @(negedge clk);
    check("irq asserted", irq, 1'b1);
    axi_read(6'h20, 32'h0000_0001, 2'b00, "istat_edge");
    axi_write(6'h20, 32'h0000_0001, 4'hF, 0, 0, 2'b00, 0, 1'b1, "w1c_vs_set");
    irq_src = 8'h00;
    axi_read(6'h20, 32'h0000_0001, 2'b00, "istat_set_wins");
    check("irq still set", irq, 1'b1);
    axi_write(6'h20, 32'h0000_00FF, 4'h0, 0, 0, 2'b00, 0, 1'b0, "w1c_nostrb");
    @(negedge clk); irq_src = 8'h80;
    @(negedge clk); irq_src = 8'h00;
    axi_read(6'h20, 32'h0000_0081, 2'b00, "istat_masked_src");
    axi_write(6'h20, 32'h0000_0081, 4'hF, 0, 0, 2'b00, 0, 1'b0, "w1c_clear");
    axi_read(6'h20, 32'h0000_0000, 2'b00, "istat_cleared");
    repeat (2) @(negedge clk);
    check("irq cleared", irq, 1'b0);

    // Reset while a write response waits on bready
    @(negedge clk);
    awaddr = 6'h00; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; t = 0;
    while (!(awready && wready) && t < TMO) begin @(negedge clk); t++; end
    check("rst_mid handshake", t < TMO, 1'b1);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < TMO) begin @(negedge clk); t++; end
    check("rst_mid bvalid pending", bvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid bvalid", bvalid, 1'b0);
    check("rst_mid ctrl_out", ctrl_out, 128'h0);
    @(negedge clk); rst = 1'b0;
    axi_read(6'h24, 32'h0, 2'b00, "rst_mid ien");
    axi_read(6'h00, 32'h0, 2'b00, "rst_mid ctrl0");

`ifdef CMLK_SYSCTRL_WDOG_EN
    axi_write(6'h28, 32'd10, 4'hF, 0, 0, 2'b00, 0, 1'b0, "wdog_load");
    t = 0;
    while (!wdog_expire && t < 4 * TMO) begin @(negedge clk); t++; end
    check("wdog expire delay", cyc - b_cyc, 10);
    axi_read(6'h20, 32'h0000_0080, 2'b00, "wdog istat");
    axi_read(6'h28, 32'h0, 2'b00, "wdog count");
    axi_write(6'h28, 32'd0, 4'hF, 0, 0, 2'b00, 0, 1'b0, "wdog_reload");
    check("wdog expire cleared", wdog_expire, 1'b0);
`endif

    check("scoreboard drained", rq.size() + bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
